// File: rtl/alu_pkg.sv
// Arithmetic-unit shared types: FSM states, default width, range helper.
// Used by the Booth multiply-add and the signed divider.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  // True when v lies outside the signed w-bit range.
  function automatic logic out_of_range(
    input logic signed [31:0] v,
    input int unsigned w
  );
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    lo = -(32'sd1 <<< (w - 1));
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return (v < lo) || (v > hi);
  endfunction

endpackage

// File: rtl/booth_mac_seq_if.sv
// Start/done handshake bundle between the ALU controller and booth_mac_seq.
// The controller holds the master side.
interface booth_mac_seq_if #(
    parameter int WIDTH = 8
);

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     addend;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 overflow8;

  modport master (
    output start, multiplicand, multiplier, addend,
    input  busy, done, product, overflow8
  );

  modport slave (
    input  start, multiplicand, multiplier, addend,
    output busy, done, product, overflow8
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of A into ACC,
// then arithmetic right shift of {ACC, Q, q_m1}.
module booth_step
  import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH:0]   acc_nx,
    output logic [WIDTH-1:0] q_nx,
    output logic             q_m1_nx
);

    logic [WIDTH:0]          a_ext;
    logic [WIDTH:0]          acc_t;
    logic signed [2*WIDTH+1:0] cat;

    // One guard bit so that negating the most negative A cannot wrap.
    assign a_ext = {a[WIDTH-1], a};

    always_comb begin
        acc_t = acc;
        unique case ({q[0], q_m1})
            2'b01:   acc_t = acc + a_ext;
            2'b10:   acc_t = acc - a_ext;
            default: acc_t = acc;
        endcase
        cat = $signed({acc_t, q, q_m1}) >>> 1;
        {acc_nx, q_nx, q_m1_nx} = cat;
    end

endmodule

// File: rtl/booth_mac_seq.sv
// Sequential signed multiply-add, product = A*B + C, one Booth step per clock.
// Result and overflow8 are registered and held until the next done.
module booth_mac_seq
  import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    booth_mac_seq_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] q_nx;
    logic             q_m1_nx;

    logic signed [2*WIDTH-1:0] sum;
    logic signed [31:0]        sum32;
    logic                      last;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .q       (q),
        .q_m1    (q_m1),
        .a       (a_q),
        .acc_nx  (acc_nx),
        .q_nx    (q_nx),
        .q_m1_nx (q_m1_nx)
    );

    assign sum   = $signed({acc[WIDTH-1:0], q})
                 + $signed({{WIDTH{c_q[WIDTH-1]}}, c_q});
    assign sum32 = 32'(sum);
    assign last  = (cnt == CW'(WIDTH - 1));
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q           <= '0;
            c_q           <= '0;
            acc           <= '0;
            q             <= '0;
            q_m1          <= 1'b0;
            cnt           <= '0;
            bus.done      <= 1'b0;
            bus.product   <= '0;
            bus.overflow8 <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q  <= bus.multiplicand;
                        c_q  <= bus.addend;
                        acc  <= '0;
                        q    <= bus.multiplier;
                        q_m1 <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_nx;
                    q    <= q_nx;
                    q_m1 <= q_m1_nx;
                    cnt  <= cnt + 1'b1;
                end
                FINISH: begin
                    bus.product   <= sum;
                    bus.overflow8 <= out_of_range(sum32, WIDTH);
                    bus.done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Directed bench for booth_mac_seq: latency, corner operands,
// back-to-back starts, ignored starts and mid-operation reset.
module tb_booth_mac_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    booth_mac_seq_if #(.WIDTH(8)) bus ();

    booth_mac_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.addend       = c;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit got, output int busy_n);
        got    = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.addend       = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
        else passed++;
        checks++;
        if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done);
        else passed++;
        checks++;
        if (bus.product !== 16'h0000)
            $display("FAIL reset_product got %h want 0000", bus.product);
        else passed++;
        checks++;
        if (bus.overflow8 !== 1'b0)
            $display("FAIL reset_ovf got %b want 0", bus.overflow8);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] c,
                            input logic [15:0] exp_p, input logic exp_o);
        bit got;
        int bn;
        launch(a, b, c);
        wait_done(got, bn);
        checks++;
        if (!got) begin
            $display("FAIL %s_timeout no done within 20 cycles", name);
            return;
        end
        passed++;
        checks++;
        if (bus.product !== exp_p)
            $display("FAIL %s_product got %h want %h", name, bus.product, exp_p);
        else passed++;
        checks++;
        if (bus.overflow8 !== exp_o)
            $display("FAIL %s_ovf got %b want %b", name, bus.overflow8, exp_o);
        else passed++;
    endtask

    task automatic test_latency();
        bit got;
        int bn;
        launch(8'd7, 8'hFD, 8'd0);
        wait_done(got, bn);
        checks++;
        if (!got) $display("FAIL lat_timeout no done within 20 cycles");
        else passed++;
        checks++;
        if (bn != 9) $display("FAIL lat_busy_cycles got %0d want 9", bn);
        else passed++;
        checks++;
        if (bus.product !== 16'hFFEB)
            $display("FAIL lat_product got %h want FFEB", bus.product);
        else passed++;
        checks++;
        if (bus.overflow8 !== 1'b0)
            $display("FAIL lat_ovf got %b want 0", bus.overflow8);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) $display("FAIL lat_done_width got %b want 0", bus.done);
        else passed++;
    endtask

    task automatic test_corners();
        check_op("minsq", 8'h80, 8'h80, 8'h00, 16'h4000, 1'b1);
        check_op("minmax", 8'h80, 8'h7F, 8'h80, 16'hC000, 1'b1);
        check_op("divinv", 8'hF2, 8'd7, 8'hFE, 16'hFF9C, 1'b0);
        check_op("zero", 8'd0, 8'hFB, 8'd0, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit got;
        int bn;
        launch(8'd3, 8'd4, 8'd0);
        launch(8'd9, 8'd9, 8'd0);
        wait_done(got, bn);
        checks++;
        if (!got || bus.product !== 16'd12)
            $display("FAIL b2b_ignore got %h done %b want 000c", bus.product, got);
        else passed++;
        bus.start        = 1'b1;
        bus.multiplicand = 8'hFF;
        bus.multiplier   = 8'hFF;
        bus.addend       = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL b2b_accept busy got %b want 1", bus.busy);
        else passed++;
        checks++;
        if (bus.product !== 16'd12)
            $display("FAIL b2b_hold got %h want 000c", bus.product);
        else passed++;
        wait_done(got, bn);
        checks++;
        if (!got || bus.product !== 16'd2)
            $display("FAIL b2b_second got %h done %b want 0002", bus.product, got);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int seen;
        launch(8'd5, 8'd5, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", bus.busy);
        else passed++;
        checks++;
        if (bus.done !== 1'b0) $display("FAIL mrst_done got %b want 0", bus.done);
        else passed++;
        checks++;
        if (bus.product !== 16'h0000)
            $display("FAIL mrst_product got %h want 0000", bus.product);
        else passed++;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        checks++;
        if (seen != 0) $display("FAIL mrst_no_done got %0d pulses want 0", seen);
        else passed++;
        check_op("fresh", 8'd6, 8'hF9, 8'd3, 16'hFFD9, 1'b0);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
